// File: rtl/and_unit_arbiter.sv
// rtl/and_unit_arbiter.sv - round-robin arbiter in front of a two-stage registered AND unit
//
// Purpose: grants at most one of NUM_REQ requesters per cycle (round robin),
// registers the granted operands in stage 1, registers x & y tagged with the
// requester index in stage 2, and counts completed operations.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-low reset
//   req        per-requester level request
//   x_in/y_in  packed operands, requester i at [i*WIDTH +: WIDTH]
//   hold       blocks new grants; the pipeline keeps draining
//   grant      combinational one-hot (or zero) grant
//   out_valid  one-cycle result strobe
//   out_z      x & y of the owning requester
//   out_id     index of the owning requester
//   op_count   completed operations, saturating at 16'hFFFF
module and_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] x_in,
    input  logic [NUM_REQ*WIDTH-1:0] y_in,
    input  logic                     hold,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_z,
    output logic [ID_W-1:0]          out_id,
    output logic [15:0]              op_count
);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_z_q, out_z_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  gnt_idx;
    logic             found;
    logic             transfer;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;

    // Scan from ptr+1 upward with wrap; the first requester hit wins.
    // Gating on reset keeps grant low during reset even though it is combinational.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        scan_idx = '0;
        if (reset && !hold) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                if (!found && req[scan_idx]) begin
                    found          = 1'b1;
                    grant[scan_idx] = 1'b1;
                    gnt_idx        = scan_idx;
                end
            end
        end
    end

    assign transfer = found;

    // Grant is one-hot, so an OR-style select picks exactly the granted lane.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_x = x_in[i*WIDTH +: WIDTH];
                sel_y = y_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d       = transfer ? gnt_idx : ptr_q;
        s1_valid_d  = transfer;
        s1_x_d      = transfer ? sel_x   : s1_x_q;
        s1_y_d      = transfer ? sel_y   : s1_y_q;
        s1_id_d     = transfer ? gnt_idx : s1_id_q;
        out_valid_d = s1_valid_q;
        out_z_d     = s1_valid_q ? (s1_x_q & s1_y_q) : out_z_q;
        out_id_d    = s1_valid_q ? s1_id_q : out_id_q;
        op_count_d  = (s1_valid_q && (op_count_q != 16'hFFFF)) ? op_count_q + 16'd1 : op_count_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_id_q     <= s1_id_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_id_q    <= out_id_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_id    = out_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// tb/tb_and_unit_arbiter.sv - scoreboard bench for and_unit_arbiter
module tb_and_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N*W-1:0] x_in = '0;
    logic [N*W-1:0] y_in = '0;
    logic         hold  = 1'b0;
    logic [N-1:0] grant;
    logic         out_valid;
    logic [W-1:0] out_z;
    logic [1:0]   out_id;
    logic [15:0]  op_count;

    and_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .hold     (hold),
        .grant    (grant),
        .out_valid(out_valid),
        .out_z    (out_z),
        .out_id   (out_id),
        .op_count (op_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] z;
        int         id;
        int         due;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   m_ptr   = N - 1;
    int   exp_cnt = 0;
    bit   done    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, want);
        end
    endtask

    // Reference: scan requesters starting after the last granted index.
    function automatic int model_pick(input bit rst_n, input bit h, input logic [N-1:0] r, input int p);
        if (!rst_n || h) return -1;
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input bit rst_n, input bit h, input logic [N-1:0] r,
                        input logic [31:0] xv, input logic [31:0] yv);
        int   pick;
        exp_t e;
        @(negedge clock);
        reset = rst_n;
        hold  = h;
        req   = r;
        x_in  = xv;
        y_in  = yv;
        #1;
        pick = model_pick(rst_n, h, r, m_ptr);
        chk("grant", 32'(grant), (pick < 0) ? 32'd0 : (32'd1 << pick));
        if (!rst_n) begin
            m_ptr   = N - 1;
            exp_cnt = 0;
            // anything not yet presented on the outputs is lost by the reset edge
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end else if (pick >= 0) begin
            e.z   = xv[pick*W +: W] & yv[pick*W +: W];
            e.id  = pick;
            e.due = cyc + 2;
            q.push_back(e);
            m_ptr = pick;
        end
    endtask

    // Monitor: compares outputs 3 time units after every edge.
    initial begin
        exp_t e;
        bit   ev;
        while (!done) begin
            @(posedge clock);
            #3;
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                e = q.pop_front();
                chk("out_z", 32'(out_z), 32'(e.z));
                chk("out_id", 32'(out_id), 32'(e.id));
                if (exp_cnt < 16'hFFFF) exp_cnt++;
            end
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("missed_result", 32'(q[0].due), 32'(cyc));
                void'(q.pop_front());
            end
            chk("op_count", 32'(op_count), 32'(exp_cnt));
        end
    end

    initial begin
        logic [31:0] xr, yr;
        logic [N-1:0] rr;
        bit hr, rs;

        // reset release with all requesting
        repeat (3) step(0, 0, 4'b1111, 32'h0, 32'h0);
        step(1, 0, 4'b1111, 32'h11223344, 32'hFFFFFFFF);
        step(0, 0, 4'b0000, 32'h0, 32'h0);

        // single op from requester 2
        step(1, 0, 4'b0100, 32'h00F00000, 32'h003C0000);
        repeat (4) step(1, 0, 4'b0000, 32'h0, 32'h0);
        step(0, 0, 4'b0000, 32'h0, 32'h0);

        // round robin with all requesting
        for (int i = 0; i < 8; i++) step(1, 0, 4'b1111, $urandom, $urandom);
        repeat (3) step(1, 0, 4'b0000, 32'h0, 32'h0);
        step(0, 0, 4'b0000, 32'h0, 32'h0);

        // wrap and skip
        step(1, 0, 4'b0100, 32'hA5A5A5A5, 32'h0F0F0F0F);
        step(1, 0, 4'b0011, 32'h5A5A5A5A, 32'hF0F0FFFF);
        repeat (3) step(1, 0, 4'b0000, 32'h0, 32'h0);
        step(0, 0, 4'b0000, 32'h0, 32'h0);

        // hold and drain
        step(1, 0, 4'b1111, $urandom, $urandom);
        step(1, 0, 4'b1111, $urandom, $urandom);
        repeat (5) step(1, 1, 4'b1111, $urandom, $urandom);
        step(0, 0, 4'b0000, 32'h0, 32'h0);

        // reset while an operation is in flight
        step(1, 0, 4'b0010, 32'h0000FF00, 32'h0000AA00);
        step(0, 0, 4'b0010, 32'h0000FF00, 32'h0000AA00);
        step(1, 0, 4'b0010, 32'h00003C00, 32'h0000FF00);
        repeat (3) step(1, 0, 4'b0000, 32'h0, 32'h0);

        // randomized traffic with occasional hold and reset
        for (int i = 0; i < 400; i++) begin
            rr = N'($urandom);
            hr = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 40) != 0);
            xr = $urandom;
            yr = $urandom;
            step(rs, hr, rr, xr, yr);
        end

        repeat (4) step(1, 0, 4'b0000, 32'h0, 32'h0);
        @(posedge clock);
        #4;
        chk("queue_drained", 32'(q.size()), 32'd0);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
